// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the convolution layer sequencer:
// FSM states, descriptor word layout and header field position.
package conv_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_FETCH,
    S_PREP,
    S_LAUNCH,
    S_WAIT_HI,
    S_WAIT_LO,
    S_NEXT,
    S_DONE,
    S_ERR
  } seq_state_t;

  localparam int DESC_OFF_IN  = 0;
  localparam int DESC_OFF_OUT = 1;
  localparam int DESC_OFF_W   = 2;

  localparam int HDR_CNT_LSB = 0;
  localparam int HDR_CNT_W   = 4;

  // Per-state cycle counter width; must cover the start timeout
  localparam int STEP_W = 8;

endpackage

// File: rtl/conv_layer_sequencer_addr_reloc.sv
// Combinational base+offset relocation of the engine's three local
// address ports; passes offsets through untouched when disabled.
module addr_reloc #(
  parameter int AW = 12
) (
  input  logic          reloc_en,
  input  logic [AW-1:0] in_base,
  input  logic [AW-1:0] out_base,
  input  logic [AW-1:0] w_base,
  input  logic [AW-1:0] eng_rd,
  input  logic [AW-1:0] eng_wr,
  input  logic [AW-1:0] eng_w,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] w_addr
);

  assign rd_addr = reloc_en ? (in_base  + eng_rd) : eng_rd;
  assign wr_addr = reloc_en ? (out_base + eng_wr) : eng_wr;
  assign w_addr  = reloc_en ? (w_base   + eng_w)  : eng_w;

endmodule

// File: rtl/conv_layer_sequencer.sv
// Walks a layer descriptor table in weight SRAM, relocating and launching
// the XNOR convolution engine once per layer.
module conv_layer_sequencer
  import conv_seq_pkg::*;
#(
  parameter int            AW            = 12,
  parameter int            DW            = 16,
  parameter logic [AW-1:0] DESC_BASE     = AW'(12'h000),
  parameter int            MAX_LAYERS    = 8,
  parameter int            START_TIMEOUT = 4
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          host_start,
  output logic          host_busy,
  output logic          host_done,
  output logic          host_err,
  output logic [3:0]    host_layer,
  output logic          eng_run,
  input  logic          eng_busy,
  input  logic [AW-1:0] eng_sram_read_address,
  input  logic [AW-1:0] eng_sram_write_address,
  input  logic          eng_sram_write_enable,
  input  logic [DW-1:0] eng_sram_write_data,
  input  logic [AW-1:0] eng_wmem_read_address,
  output logic [AW-1:0] sram_read_address,
  output logic [AW-1:0] sram_write_address,
  output logic          sram_write_enable,
  output logic [DW-1:0] sram_write_data,
  output logic [AW-1:0] wmem_read_address,
  input  logic [DW-1:0] wmem_read_data
);

  localparam logic [3:0]        MAX_CNT  = 4'(MAX_LAYERS);
  localparam logic [STEP_W-1:0] TO_LAST  = STEP_W'(START_TIMEOUT - 1);

  seq_state_t        state_q, next_state;
  logic [STEP_W-1:0] step_q;
  logic [3:0]        count_q, layer_q, hdr_count;
  logic [AW-1:0]     in_base_q, out_base_q, w_base_q;
  logic              host_err_q, reloc_en, wr_gate;
  logic [AW-1:0]     layer_ext, fetch_addr, reloc_w_addr;

  assign hdr_count  = wmem_read_data[HDR_CNT_LSB +: HDR_CNT_W];
  assign layer_ext  = AW'(layer_q);
  assign fetch_addr = DESC_BASE + AW'(1) + (layer_ext << 1) + layer_ext + AW'(step_q);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state_q <= S_IDLE;
    else          state_q <= next_state;
  end

  always_comb begin
    next_state = state_q;
    eng_run    = 1'b0;
    host_busy  = 1'b1;
    host_done  = 1'b0;
    reloc_en   = 1'b0;
    wr_gate    = 1'b0;
    case (state_q)
      S_IDLE: begin
        host_busy = 1'b0;
        if (host_start) next_state = S_HDR;
      end
      // Second HDR cycle sees the header word returned by the weight SRAM
      S_HDR: begin
        if (step_q == STEP_W'(1)) begin
          if (hdr_count == 4'd0)         next_state = S_DONE;
          else if (hdr_count > MAX_CNT)  next_state = S_ERR;
          else                           next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        if (step_q == STEP_W'(3)) next_state = S_PREP;
      end
      S_PREP: begin
        reloc_en   = 1'b1;
        next_state = S_LAUNCH;
      end
      S_LAUNCH: begin
        reloc_en   = 1'b1;
        eng_run    = 1'b1;
        next_state = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        reloc_en = 1'b1;
        if (eng_busy)              next_state = S_WAIT_LO;
        else if (step_q == TO_LAST) next_state = S_ERR;
      end
      S_WAIT_LO: begin
        reloc_en = 1'b1;
        wr_gate  = 1'b1;
        if (!eng_busy) next_state = S_NEXT;
      end
      S_NEXT: begin
        if ((layer_q + 4'd1) == count_q) next_state = S_DONE;
        else                             next_state = S_FETCH;
      end
      S_DONE: begin
        host_busy  = 1'b0;
        host_done  = 1'b1;
        next_state = S_IDLE;
      end
      S_ERR: begin
        host_busy  = 1'b0;
        next_state = S_IDLE;
      end
      default: begin
        host_busy  = 1'b0;
        next_state = S_IDLE;
      end
    endcase
  end

  // Descriptor words land one cycle after their address, so FETCH step k+1 captures word k
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      step_q     <= '0;
      count_q    <= '0;
      layer_q    <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      w_base_q   <= '0;
      host_err_q <= 1'b0;
    end else begin
      step_q <= (next_state != state_q) ? '0 : step_q + 1'b1;
      if (next_state == S_ERR)                host_err_q <= 1'b1;
      else if (state_q == S_IDLE && host_start) host_err_q <= 1'b0;
      case (state_q)
        S_IDLE: if (host_start) layer_q <= '0;
        S_HDR:  if (step_q == STEP_W'(1)) count_q <= hdr_count;
        S_FETCH: begin
          if (step_q == STEP_W'(DESC_OFF_IN + 1))  in_base_q  <= wmem_read_data[AW-1:0];
          if (step_q == STEP_W'(DESC_OFF_OUT + 1)) out_base_q <= wmem_read_data[AW-1:0];
          if (step_q == STEP_W'(DESC_OFF_W + 1))   w_base_q   <= wmem_read_data[AW-1:0];
        end
        S_NEXT: if (next_state == S_FETCH) layer_q <= layer_q + 4'd1;
        default: ;
      endcase
    end
  end

  addr_reloc #(.AW(AW)) u_reloc (
    .reloc_en (reloc_en),
    .in_base  (in_base_q),
    .out_base (out_base_q),
    .w_base   (w_base_q),
    .eng_rd   (eng_sram_read_address),
    .eng_wr   (eng_sram_write_address),
    .eng_w    (eng_wmem_read_address),
    .rd_addr  (sram_read_address),
    .wr_addr  (sram_write_address),
    .w_addr   (reloc_w_addr)
  );

  assign wmem_read_address = (state_q == S_HDR)   ? DESC_BASE  :
                             (state_q == S_FETCH) ? fetch_addr : reloc_w_addr;
  assign sram_write_enable = wr_gate & eng_sram_write_enable;
  assign sram_write_data   = eng_sram_write_data;
  assign host_err          = host_err_q;
  assign host_layer        = layer_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer: weight-SRAM descriptor model plus a
// hand-driven engine, with hand-computed expected addresses and flag timing.
module tb_conv_layer_sequencer;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_b;
  logic          host_start;
  logic          host_busy, host_done, host_err;
  logic [3:0]    host_layer;
  logic          eng_run;
  logic          eng_busy;
  logic [AW-1:0] eng_rd, eng_wr, eng_w;
  logic          eng_we;
  logic [DW-1:0] eng_wdata;
  logic [AW-1:0] sram_read_address, sram_write_address, wmem_read_address;
  logic          sram_write_enable;
  logic [DW-1:0] sram_write_data;
  logic [DW-1:0] wmem_read_data;

  logic [DW-1:0] wmem [0:4095];
  logic [AW-1:0] prev_rd, prev2_rd;
  int            checks = 0;
  int            passes = 0;
  int            run_count = 0;
  int            runs_before;
  bit            seen_run;

  conv_layer_sequencer dut (
    .clk                    (clk),
    .reset_b                (reset_b),
    .host_start             (host_start),
    .host_busy              (host_busy),
    .host_done              (host_done),
    .host_err               (host_err),
    .host_layer             (host_layer),
    .eng_run                (eng_run),
    .eng_busy               (eng_busy),
    .eng_sram_read_address  (eng_rd),
    .eng_sram_write_address (eng_wr),
    .eng_sram_write_enable  (eng_we),
    .eng_sram_write_data    (eng_wdata),
    .eng_wmem_read_address  (eng_w),
    .sram_read_address      (sram_read_address),
    .sram_write_address     (sram_write_address),
    .sram_write_enable      (sram_write_enable),
    .sram_write_data        (sram_write_data),
    .wmem_read_address      (wmem_read_address),
    .wmem_read_data         (wmem_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) wmem_read_data <= wmem[wmem_read_address];

  always @(posedge clk) if (reset_b === 1'b1 && eng_run === 1'b1) run_count <= run_count + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic applyStimulus;
    @(negedge clk);
    host_start = 1'b1;
    @(negedge clk);
    host_start = 1'b0;
  endtask

  task automatic clearTable;
    for (int i = 0; i < 32; i++) wmem[i] = '0;
  endtask

  task automatic setLayer(input int idx, input logic [11:0] ib, input logic [11:0] ob,
                          input logic [11:0] wb);
    wmem[1 + 3*idx] = {4'b0, ib};
    wmem[2 + 3*idx] = {4'b0, ob};
    wmem[3 + 3*idx] = {4'b0, wb};
  endtask

  // Waits (bounded) for the run pulse, remembering the two read addresses before it
  task automatic waitRun(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (eng_run === 1'b1) begin
        seen = 1'b1;
        break;
      end
      prev2_rd = prev_rd;
      prev_rd  = sram_read_address;
    end
    if (!seen) checkOutput("eng_run_timeout", 32'd0, 32'd1);
  endtask

  task automatic runLayer(input int layer, input logic [11:0] ib, input logic [11:0] ob,
                          input logic [11:0] wb, input int busy_len);
    bit seen;
    eng_rd = 12'h005;
    eng_wr = 12'h003;
    eng_w  = 12'h001;
    eng_we = 1'b0;
    waitRun(seen);
    if (seen) begin
      checkOutput("host_layer", 32'(host_layer), 32'(layer));
      checkOutput("prep_reloc_rd", 32'(prev_rd), 32'(ib) + 32'h5);
      checkOutput("fetch_unreloc_rd", 32'(prev2_rd), 32'h5);
      @(negedge clk);
      eng_busy = 1'b1;
      #1 checkOutput("run_pulse_width", 32'(eng_run), 32'd0);
      @(negedge clk);
      eng_we    = 1'b1;
      eng_wdata = 16'hA5C3 ^ 16'(layer);
      #1;
      checkOutput("reloc_rd", 32'(sram_read_address), 32'(ib) + 32'h5);
      checkOutput("reloc_wr", 32'(sram_write_address), 32'(ob) + 32'h3);
      checkOutput("reloc_w", 32'(wmem_read_address), 32'(wb) + 32'h1);
      checkOutput("wr_enable_pass", 32'(sram_write_enable), 32'd1);
      checkOutput("wr_data_pass", 32'(sram_write_data), 32'(16'hA5C3 ^ 16'(layer)));
      repeat (busy_len) @(negedge clk);
      eng_we   = 1'b0;
      eng_busy = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_b    = 1'b0;
    host_start = 1'b0;
    eng_busy   = 1'b0;
    eng_rd     = 12'h123;
    eng_wr     = 12'h045;
    eng_w      = 12'h067;
    eng_we     = 1'b1;
    eng_wdata  = 16'h0;
    prev_rd    = '0;
    prev2_rd   = '0;
    clearTable();

    // Reset values and IDLE pass-through
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_busy", 32'(host_busy), 32'd0);
    checkOutput("rst_done", 32'(host_done), 32'd0);
    checkOutput("rst_err", 32'(host_err), 32'd0);
    checkOutput("rst_run", 32'(eng_run), 32'd0);
    checkOutput("rst_layer", 32'(host_layer), 32'd0);
    checkOutput("rst_we_blocked", 32'(sram_write_enable), 32'd0);
    checkOutput("idle_rd_pass", 32'(sram_read_address), 32'h123);
    checkOutput("idle_wr_pass", 32'(sram_write_address), 32'h045);
    @(negedge clk);
    reset_b = 1'b1;
    eng_we  = 1'b0;

    // Count = 0
    $display("[TB] empty table");
    runs_before = run_count;
    applyStimulus();
    #1;
    checkOutput("c0_busy_hdr", 32'(host_busy), 32'd1);
    @(negedge clk);
    #1 checkOutput("c0_done_early", 32'(host_done), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("c0_done", 32'(host_done), 32'd1);
    checkOutput("c0_busy_low", 32'(host_busy), 32'd0);
    checkOutput("c0_err", 32'(host_err), 32'd0);
    @(negedge clk);
    #1 checkOutput("c0_done_pulse", 32'(host_done), 32'd0);
    checkOutput("c0_no_run", 32'(run_count - runs_before), 32'd0);

    // Count = 1
    $display("[TB] single layer");
    clearTable();
    wmem[0] = 16'd1;
    setLayer(0, 12'h040, 12'h200, 12'h010);
    runs_before = run_count;
    applyStimulus();
    runLayer(0, 12'h040, 12'h200, 12'h010, 3);
    @(negedge clk);
    eng_we = 1'b1;
    #1;
    checkOutput("c1_we_blocked_next", 32'(sram_write_enable), 32'd0);
    checkOutput("c1_done_early", 32'(host_done), 32'd0);
    @(negedge clk);
    eng_we = 1'b0;
    #1;
    checkOutput("c1_done", 32'(host_done), 32'd1);
    checkOutput("c1_busy_low", 32'(host_busy), 32'd0);
    checkOutput("c1_runs", 32'(run_count - runs_before), 32'd1);

    // Count = 3, ping-pong bases
    $display("[TB] three layers");
    clearTable();
    wmem[0] = 16'd3;
    setLayer(0, 12'h100, 12'h300, 12'h020);
    setLayer(1, 12'h300, 12'h100, 12'h040);
    setLayer(2, 12'h100, 12'h300, 12'h060);
    runs_before = run_count;
    applyStimulus();
    runLayer(0, 12'h100, 12'h300, 12'h020, 2);
    runLayer(1, 12'h300, 12'h100, 12'h040, 4);
    runLayer(2, 12'h100, 12'h300, 12'h060, 1);
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("c3_done", 32'(host_done), 32'd1);
    checkOutput("c3_runs", 32'(run_count - runs_before), 32'd3);

    // Count = 9 exceeds the layer limit
    $display("[TB] oversize table");
    clearTable();
    wmem[0] = 16'd9;
    runs_before = run_count;
    applyStimulus();
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("c9_err", 32'(host_err), 32'd1);
    checkOutput("c9_busy_low", 32'(host_busy), 32'd0);
    checkOutput("c9_no_done", 32'(host_done), 32'd0);
    repeat (6) @(negedge clk);
    #1;
    checkOutput("c9_err_sticky", 32'(host_err), 32'd1);
    checkOutput("c9_no_run", 32'(run_count - runs_before), 32'd0);

    // Engine never raises busy
    $display("[TB] start timeout");
    clearTable();
    wmem[0] = 16'd1;
    setLayer(0, 12'h040, 12'h200, 12'h010);
    runs_before = run_count;
    applyStimulus();
    waitRun(seen_run);
    if (seen_run) begin
      repeat (4) @(negedge clk);
      #1;
      checkOutput("to_err_wait", 32'(host_err), 32'd0);
      checkOutput("to_busy_wait", 32'(host_busy), 32'd1);
      @(negedge clk);
      #1;
      checkOutput("to_err", 32'(host_err), 32'd1);
      checkOutput("to_busy_low", 32'(host_busy), 32'd0);
    end
    repeat (8) @(negedge clk);
    checkOutput("to_runs", 32'(run_count - runs_before), 32'd1);
    applyStimulus();
    #1 checkOutput("to_err_cleared", 32'(host_err), 32'd0);
    runLayer(0, 12'h040, 12'h200, 12'h010, 2);
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("to_retry_done", 32'(host_done), 32'd1);
    checkOutput("to_retry_err", 32'(host_err), 32'd0);

    // Reset while the engine is writing
    $display("[TB] reset during write");
    applyStimulus();
    eng_rd = 12'h005;
    eng_wr = 12'h003;
    eng_w  = 12'h001;
    waitRun(seen_run);
    if (seen_run) begin
      @(negedge clk);
      eng_busy = 1'b1;
      @(negedge clk);
      eng_we = 1'b1;
      #1 checkOutput("mr_we_before", 32'(sram_write_enable), 32'd1);
      #2 reset_b = 1'b0;
      #1;
      checkOutput("mr_we_killed", 32'(sram_write_enable), 32'd0);
      checkOutput("mr_busy", 32'(host_busy), 32'd0);
      checkOutput("mr_idle_rd", 32'(sram_read_address), 32'h005);
      checkOutput("mr_idle_wr", 32'(sram_write_address), 32'h003);
    end
    @(negedge clk);
    reset_b  = 1'b1;
    eng_busy = 1'b0;
    eng_we   = 1'b0;
    clearTable();
    applyStimulus();
    @(negedge clk);
    @(negedge clk);
    #1 checkOutput("mr_recover_done", 32'(host_done), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/conv_layer_sequencer.md
Name: conv_layer_sequencer

Overview:
- Sequences the binary 3x3 XNOR-convolution engine over a list of layers described in a descriptor table held in weight SRAM.
- Sits between the host control signals, the engine's run/busy and SRAM ports, and the physical input/output SRAM and weight SRAM.
- For each layer it relocates the engine's local addresses by per-layer base offsets, launches the engine, and waits for it to finish.

Parameters:
- AW, 12, SRAM/WMEM address width
- DW, 16, SRAM/WMEM data width
- DESC_BASE, 12'h000, weight-SRAM address of the descriptor header
- MAX_LAYERS, 8, maximum legal layer count
- START_TIMEOUT, 4, cycles allowed after eng_run before eng_busy must rise

Ports:
- clk  in  1  clock
- reset_b  in  1  async active-low reset
- host_start  in  1  start request, sampled in IDLE
- host_busy  out  1  high from accepted start until DONE/ERR exit
- host_done  out  1  one-cycle pulse on successful completion
- host_err  out  1  sticky error flag, cleared on next accepted start
- host_layer  out  4  index of the layer currently running
- eng_run  out  1  engine start pulse
- eng_busy  in  1  engine busy
- eng_sram_read_address  in  AW  engine local read address
- eng_sram_write_address  in  AW  engine local write address
- eng_sram_write_enable  in  1  engine write enable
- eng_sram_write_data  in  DW  engine write data
- eng_wmem_read_address  in  AW  engine local weight address
- sram_read_address  out  AW  physical input SRAM read address
- sram_write_address  out  AW  physical output SRAM write address
- sram_write_enable  out  1  physical write enable
- sram_write_data  out  DW  physical write data
- wmem_read_address  out  AW  physical weight SRAM read address
- wmem_read_data  in  DW  weight SRAM data (1-cycle latency); also forwarded to the engine by top-level wiring

Behaviour:
- Reset:
  - State IDLE; all flags 0; eng_run 0; host_layer 0.
  - in_base, out_base and w_base registers are 0.
- Memory and address rules:
  - Both SRAMs have 1-cycle read latency.
  - Descriptor table: header word at DESC_BASE, layer count in bits [3:0]. Layer i occupies words DESC_BASE+1+3i .. +3i+2, holding in_base, out_base and w_base in order.
  - Address arithmetic is AW bits modulo 2^AW; no overflow detection.
- States: IDLE -> HDR -> FETCH -> PREP -> LAUNCH -> WAIT_HI -> WAIT_LO -> NEXT, plus DONE and ERR.
- IDLE:
  - host_start=1 -> HDR, host_busy=1, host_err cleared.
  - Memory ports pass through the engine addresses unrelocated; sram_write_enable is forced 0.
- HDR:
  - Drive wmem_read_address=DESC_BASE.
  - Next cycle capture count. count=0 -> DONE; count>MAX_LAYERS -> ERR; otherwise FETCH with layer=0.
- FETCH:
  - Issue 3 consecutive reads: DESC_BASE+1+3*layer+k, k=0..2.
  - Capture each word one cycle after its issue (pipelined). Takes 4 cycles, then PREP.
- PREP (1 cycle):
  - Relocation becomes active: sram_read_address = in_base + eng_sram_read_address.
  - Purpose: the engine samples valid image-header data on the run cycle.
- LAUNCH (1 cycle):
  - eng_run=1, then WAIT_HI.
- WAIT_HI:
  - eng_busy=1 -> WAIT_LO.
  - START_TIMEOUT cycles elapse with no busy -> ERR.
- WAIT_LO:
  - Relocation active on all ports: sram_write_address = out_base + eng_sram_write_address; wmem_read_address = w_base + eng_wmem_read_address.
  - sram_write_enable = eng_sram_write_enable; write data passed through unregistered.
  - eng_busy falls -> NEXT.
- NEXT:
  - layer+1 == count -> DONE; otherwise layer++ and go to FETCH.
- DONE: host_done pulse for 1 cycle, host_busy=0, -> IDLE.
- ERR: host_err=1, host_busy=0, -> IDLE. eng_run is never asserted again until the next start.
- Simultaneous events:
  - host_start outside IDLE is ignored.
  - eng_write_enable outside WAIT_LO is blocked.
- Reset mid-operation: returns immediately to the reset values; no write enable escapes.
- Latency per layer: 1 + 4 + 1 + 1 cycles of overhead plus engine run time; 2 cycles header overhead per job.

Decomposition:
- Shared package conv_seq_pkg:
  - state enum
  - descriptor word offsets (IN=0, OUT=1, W=2)
  - header count field position
- Sub-module addr_reloc: combinational base+offset mux for the three address ports, selected by a relocation-enable input. It keeps the FSM file focused on sequencing.

Test Plan:
- Header count=0 -> host_done 3 cycles after start, eng_run never asserted, host_err=0.
- Count=1, in_base=0x040, out_base=0x200, w_base=0x010:
  - Engine read addr 0x005 -> sram_read_address 0x045.
  - Engine write addr 0x003 -> sram_write_address 0x203.
  - Engine wmem addr 0x001 -> wmem_read_address 0x011.
  - host_done follows busy fall by 2 cycles.
- Count=3 with ping-pong bases (layer1 in_base = layer0 out_base) -> host_layer steps 0,1,2; exactly 3 eng_run pulses; each pulse preceded by one PREP cycle.
- Count=9 (> MAX_LAYERS) -> ERR, host_err=1, no eng_run.
- Engine model never raises busy -> ERR after 4 cycles. A following start with a valid table clears host_err and completes.
- reset_b asserted during WAIT_LO with eng_write_enable=1 -> sram_write_enable=0 immediately, state IDLE, host_busy=0.
